// File: rtl/mips_cpu_alu_unit.sv
// MIPS ALU: combinational result/zero path plus single-cycle hi/lo
// multiply/divide registers with asynchronous active-high reset.
module mips_cpu_alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        write,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // aluop classes from the main controller
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_RTYP = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;

  // R-type function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_rtype;
  logic [31:0] w_result;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  // R-type decode; unlisted function codes (including mult/div) yield 0
  always_comb begin
    w_rtype = 32'h0;
    case (funct)
      F_SLL:          w_rtype = b << shamt;
      F_SRL:          w_rtype = b >> shamt;
      F_SRA:          w_rtype = $unsigned($signed(b) >>> shamt);
      F_SLLV:         w_rtype = b << a[4:0];
      F_SRLV:         w_rtype = b >> a[4:0];
      F_SRAV:         w_rtype = $unsigned($signed(b) >>> a[4:0]);
      F_JR, F_JALR:   w_rtype = a;
      F_MFHI:         w_rtype = r_hi;
      F_MFLO:         w_rtype = r_lo;
      F_ADDU:         w_rtype = w_sum;
      F_SUBU:         w_rtype = w_diff;
      F_AND:          w_rtype = a & b;
      F_OR:           w_rtype = a | b;
      F_XOR:          w_rtype = a ^ b;
      F_NOR:          w_rtype = ~(a | b);
      F_SLT:          w_rtype = {31'b0, w_slt};
      F_SLTU:         w_rtype = {31'b0, w_sltu};
      default:        w_rtype = 32'h0;
    endcase
  end

  // Top-level operation select; undefined aluop codes fall back to ADD
  always_comb begin
    w_result = w_sum;
    case (aluop)
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_RTYP: w_result = w_rtype;
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_XOR:  w_result = a ^ b;
      OP_SLT:  w_result = {31'b0, w_slt};
      OP_SLTU: w_result = {31'b0, w_sltu};
      OP_LUI:  w_result = {b[15:0], 16'h0};
      default: w_result = w_sum;
    endcase
  end

  assign result = w_result;
  assign zero   = (w_result == 32'h0);

  // 64-bit products; the signed one is the product of sign-extended operands
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'h0, a} * {32'h0, b};

  // Division: signed form works on magnitudes so 0x80000000 / -1 needs no
  // special case. Divisor forced to 1 when b==0 to keep the datapath defined;
  // the register update is suppressed in that case anyway.
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_div_u;
  logic [31:0] w_div_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic        w_b_zero;

  assign w_b_zero = (b == 32'h0);
  assign w_a_mag  = a[31] ? (32'h0 - a) : a;
  assign w_b_mag  = b[31] ? (32'h0 - b) : b;
  assign w_div_u  = w_b_zero ? 32'd1 : b;
  assign w_div_s  = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_u    = a / w_div_u;
  assign w_r_u    = a % w_div_u;
  assign w_q_mag  = w_a_mag / w_div_s;
  assign w_r_mag  = w_a_mag % w_div_s;
  assign w_q_s    = (a[31] ^ b[31]) ? (32'h0 - w_q_mag) : w_q_mag;
  assign w_r_s    = a[31] ? (32'h0 - w_r_mag) : w_r_mag;

  // hi/lo registers: cleared asynchronously, updated only by mult/div/mt* writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (write && (aluop == OP_RTYP)) begin
      case (funct)
        F_MULT: begin
          r_hi <= w_prod_s[63:32];
          r_lo <= w_prod_s[31:0];
        end
        F_MULTU: begin
          r_hi <= w_prod_u[63:32];
          r_lo <= w_prod_u[31:0];
        end
        F_DIV: begin
          if (!w_b_zero) begin
            r_hi <= w_r_s;
            r_lo <= w_q_s;
          end
        end
        F_DIVU: begin
          if (!w_b_zero) begin
            r_hi <= w_r_u;
            r_lo <= w_q_u;
          end
        end
        F_MTHI:  r_hi <= a;
        F_MTLO:  r_lo <= a;
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mips_cpu_alu_unit.sv
// Self-checking bench for mips_cpu_alu_unit: directed vectors, randomized
// ALU and hi/lo traffic against an arithmetic reference model, reset cases.
module tb_mips_cpu_alu_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic        write;
  logic [31:0] result;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // reference-model copy of hi/lo
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  logic [5:0] alu_functs [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                  6'h08, 6'h09, 6'h10, 6'h12, 6'h21, 6'h23,
                                  6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                  6'h18, 6'h3F};
  logic [5:0] hl_functs  [7]  = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10};

  mips_cpu_alu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .aluop  (aluop),
    .funct  (funct),
    .shamt  (shamt),
    .a      (a),
    .b      (b),
    .write  (write),
    .result (result),
    .zero   (zero),
    .hi     (hi),
    .lo     (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: plain 64-bit integer arithmetic on the operand values
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [5:0] fn,
                                            input logic [4:0] sh, input logic [31:0] x,
                                            input logic [31:0] y);
    longint unsigned ux, uy, r;
    longint sx, sy;
    int s, v;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    s  = int'(sh);
    v  = int'(ux % 32);
    r  = ux + uy;
    case (op)
      4'd1: r = ux - uy;
      4'd3: r = ux & uy;
      4'd4: r = ux | uy;
      4'd5: r = ux ^ uy;
      4'd6: r = (sx < sy) ? 1 : 0;
      4'd7: r = (ux < uy) ? 1 : 0;
      4'd8: r = (uy % 65536) * 65536;
      4'd2: begin
        case (fn)
          6'h00: r = uy << s;
          6'h02: r = uy >> s;
          6'h03: r = longint'(sy >>> s);
          6'h04: r = uy << v;
          6'h06: r = uy >> v;
          6'h07: r = longint'(sy >>> v);
          6'h08, 6'h09: r = ux;
          6'h10: r = {32'h0, m_hi};
          6'h12: r = {32'h0, m_lo};
          6'h21: r = ux + uy;
          6'h23: r = ux - uy;
          6'h24: r = ux & uy;
          6'h25: r = ux | uy;
          6'h26: r = ux ^ uy;
          6'h27: r = ~(ux | uy);
          6'h2A: r = (sx < sy) ? 1 : 0;
          6'h2B: r = (ux < uy) ? 1 : 0;
          default: r = 0;
        endcase
      end
      default: r = ux + uy;
    endcase
    return r[31:0];
  endfunction

  // Reference hi/lo update for an honoured write edge
  task automatic model_write(input logic [3:0] op, input logic [5:0] fn,
                             input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, rm;
    longint unsigned ux, uy, pu, qu, ru;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (op == 4'd2) begin
      case (fn)
        6'h18: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h19: begin pu = ux * uy; m_hi = pu[63:32]; m_lo = pu[31:0]; end
        6'h1A: if (y != 0) begin
          q = sx / sy; rm = sx % sy; m_lo = q[31:0]; m_hi = rm[31:0];
        end
        6'h1B: if (y != 0) begin
          qu = ux / uy; ru = ux % uy; m_lo = qu[31:0]; m_hi = ru[31:0];
        end
        6'h11: m_hi = x;
        6'h13: m_lo = x;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y, input logic wr);
    aluop = op;
    funct = fn;
    shamt = sh;
    a     = x;
    b     = y;
    write = wr;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd2, 6'h11, 5'd0, 32'h12345678, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_initial hi=%h lo=%h required 0/0", hi, lo);
    end
    @(posedge clk); #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_write_ignored hi=%h lo=%h required 0/0", hi, lo);
    end
    $display("reset: hi=%h lo=%h", hi, lo);
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_directed_alu();
    logic [3:0]  t_op  [7] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd6, 4'd7, 4'd8};
    logic [5:0]  t_fn  [7] = '{6'h00, 6'h00, 6'h03, 6'h06, 6'h00, 6'h00, 6'h00};
    logic [4:0]  t_sh  [7] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] t_a   [7] = '{32'h7FFFFFFF, 32'h5, 32'h0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_b   [7] = '{32'h1, 32'h5, 32'h80000000, 32'h80000000, 32'h1, 32'h1, 32'h0000ABCD};
    logic [31:0] t_exp [7] = '{32'h80000000, 32'h0, 32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'hABCD0000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(t_op[i], t_fn[i], t_sh[i], t_a[i], t_b[i], 1'b0);
      #1;
      n_checks++;
      if (result !== t_exp[i] || zero !== (t_exp[i] == 32'h0)) begin
        n_fail++;
        $display("FAIL directed_alu[%0d] result=%h zero=%b required %h/%b",
                 i, result, zero, t_exp[i], (t_exp[i] == 32'h0));
      end
      $display("alu op=%h fn=%h a=%h b=%h -> %h z=%b", t_op[i], t_fn[i], t_a[i], t_b[i], result, zero);
    end
  endtask

  task automatic test_directed_hilo();
    logic [3:0]  t_op [10] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd2, 4'd2};
    logic [5:0]  t_fn [10] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1A, 6'h11, 6'h13, 6'h18, 6'h18, 6'h2A};
    logic        t_wr [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_a  [10] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h7, 32'h80000000,
                               32'hDEADBEEF, 32'h0BADF00D, 32'h3, 32'h5, 32'h9};
    logic [31:0] t_b  [10] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'hFFFFFFFF,
                               32'h0, 32'h0, 32'h3, 32'h5, 32'h9};
    logic [31:0] t_hi [10] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    logic [31:0] t_lo [10] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000,
                               32'h80000000, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(t_op[i], t_fn[i], 5'd0, t_a[i], t_b[i], t_wr[i]);
      @(posedge clk); #1;
      if (t_wr[i]) model_write(t_op[i], t_fn[i], t_a[i], t_b[i]);
      n_checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        n_fail++;
        $display("FAIL directed_hilo[%0d] hi=%h lo=%h required %h/%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
      $display("hilo op=%h fn=%h wr=%b a=%h b=%h -> hi=%h lo=%h", t_op[i], t_fn[i], t_wr[i], t_a[i], t_b[i], hi, lo);
    end
    @(negedge clk);
    drive(4'd2, 6'h10, 5'd0, 32'h0, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (result !== 32'hDEADBEEF || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL mfhi result=%h zero=%b required deadbeef/0", result, zero);
    end
    funct = 6'h12;
    #1;
    n_checks++;
    if (result !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL mflo result=%h required 0badf00d", result);
    end
    $display("mfhi/mflo hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_random_alu();
    logic [31:0] exp;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)), alu_functs[$urandom_range(0, 19)],
            5'($urandom), pick_operand(), pick_operand(), 1'b0);
      if ($urandom_range(0, 1) == 1) aluop = 4'd2;
      #1;
      exp = model_alu(aluop, funct, shamt, a, b);
      n_checks++;
      if (result !== exp || zero !== (exp == 32'h0)) begin
        n_fail++;
        $display("FAIL random_alu op=%h fn=%h sh=%0d a=%h b=%h result=%h zero=%b required %h/%b",
                 aluop, funct, shamt, a, b, result, zero, exp, (exp == 32'h0));
      end
      $display("ralu op=%h fn=%h a=%h b=%h -> %h", aluop, funct, a, b, result);
    end
  endtask

  task automatic test_random_hilo();
    logic [31:0] y;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      y = ($urandom_range(0, 6) == 0) ? 32'h0 : pick_operand();
      drive(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd2,
            ($urandom_range(0, 7) == 0) ? 6'($urandom) : hl_functs[$urandom_range(0, 6)],
            5'd0, pick_operand(), y, ($urandom_range(0, 3) != 0));
      @(posedge clk); #1;
      if (write) model_write(aluop, funct, a, b);
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL random_hilo op=%h fn=%h wr=%b a=%h b=%h hi=%h lo=%h required %h/%h",
                 aluop, funct, write, a, b, hi, lo, m_hi, m_lo);
      end
      $display("rhilo op=%h fn=%h wr=%b a=%h b=%h -> hi=%h lo=%h", aluop, funct, write, a, b, hi, lo);
    end
  endtask

  // Consecutive writes with write held high; MFHI with write=1 sees the old hi
  task automatic test_back_to_back();
    logic [31:0] old_hi;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(4'd2, hl_functs[$urandom_range(0, 5)], 5'd0, pick_operand(), pick_operand(), 1'b1);
      @(posedge clk); #1;
      model_write(aluop, funct, a, b);
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL back_to_back fn=%h hi=%h lo=%h required %h/%h", funct, hi, lo, m_hi, m_lo);
      end
      $display("b2b fn=%h a=%h b=%h -> hi=%h lo=%h", funct, a, b, hi, lo);
    end
    @(negedge clk);
    old_hi = m_hi;
    drive(4'd2, 6'h10, 5'd0, 32'h0, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (result !== old_hi) begin
      n_fail++;
      $display("FAIL same_cycle_mfhi result=%h required %h", result, old_hi);
    end
    @(posedge clk); #1;
    n_checks++;
    if (hi !== old_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL mfhi_write_no_update hi=%h lo=%h required %h/%h", hi, lo, old_hi, m_lo);
    end
    $display("same-cycle mfhi result=%h hi=%h", result, hi);
  endtask

  task automatic test_reset_mid();
    logic [31:0] val;
    val = $urandom | 32'h1;
    @(negedge clk);
    drive(4'd2, 6'h11, 5'd0, 32'hCAFE0001, 32'h0, 1'b1);
    @(negedge clk);
    drive(4'd2, 6'h13, 5'd0, 32'hCAFE0002, 32'h0, 1'b1);
    @(negedge clk);
    write = 1'b0;
    #2;
    reset = 1'b1;
    drive(4'd0, 6'h00, 5'd0, 32'h3, 32'h4, 1'b0);
    #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async hi=%h lo=%h required 0/0", hi, lo);
    end
    n_checks++;
    if (result !== 32'h7 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb_path result=%h required 00000007", result);
    end
    drive(4'd2, 6'h11, 5'd0, val, 32'h0, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold_write hi=%h lo=%h required 0/0", hi, lo);
    end
    funct = 6'h10;
    #1;
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mfhi result=%h zero=%b required 0/1", result, zero);
    end
    funct = 6'h11;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    @(posedge clk); #1;
    model_write(aluop, funct, a, b);
    n_checks++;
    if (hi !== val || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_write hi=%h lo=%h required %h/0", hi, lo, val);
    end
    $display("reset-mid val=%h -> hi=%h lo=%h", val, hi, lo);
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    drive(4'd0, 6'h00, 5'd0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_directed_alu();
    test_directed_hilo();
    test_random_alu();
    test_random_hilo();
    test_back_to_back();
    test_reset_mid();
    test_random_alu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_alu_unit.md
MIPS_CPU_ALU_UNIT -- requirements
Module: mips_cpu_alu_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock; only the hi/lo registers use it.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears hi and lo.
REQ-004 Port: aluop  in  4  operation class from the main controller.
REQ-005 Port: funct  in  6  instruction[5:0]; decoded only when aluop=0010.
REQ-006 Port: shamt  in  5  instruction[10:6]; shift amount for SLL/SRL/SRA.
REQ-007 Port: a  in  32  operand A (rs, or PC).
REQ-008 Port: b  in  32  operand B (rt, immediate, or constant).
REQ-009 Port: write  in  1  hi/lo update enable for the current cycle.
REQ-010 Port: result  out  32  combinational ALU result.
REQ-011 Port: zero  out  1  result==0.
REQ-012 Port: hi, lo  out  32 each  registered multiply/divide results.

Function: combinational ALU
REQ-013 result and zero SHALL be purely combinational from aluop, funct, shamt, a, b, hi and lo.
- No cycles of latency.
REQ-014 The aluop encoding SHALL be:
- 0000 ADD a+b
- 0001 SUB a-b
- 0010 R-type, decoded by funct
- 0011 AND
- 0100 OR
- 0101 XOR
- 0110 SLT signed
- 0111 SLTU
- 1000 LUI: {b[15:0],16'h0}
- 1001-1111 behave as ADD
REQ-015 The R-type funct decode (hex) SHALL be:
- 00 SLL b<<shamt; 02 SRL; 03 SRA (arithmetic)
- 04 SLLV b<<a[4:0]; 06 SRLV; 07 SRAV
- 08/09 JR/JALR: result=a
- 10 MFHI: result=hi; 12 MFLO: result=lo
- 21 ADDU; 23 SUBU; 24 AND; 25 OR; 26 XOR; 27 NOR
- 2A SLT; 2B SLTU
- Any other funct: result=0
REQ-016 All add/subtract SHALL wrap modulo 2^32.
- No overflow trap and no overflow output.
REQ-017 SLT/SLTU SHALL produce 32'h1 when true and 32'h0 when false.
REQ-018 zero SHALL be 1 if and only if result==32'h0, for every operation.

Function: hi/lo (mult/div)
REQ-019 When write=1 and aluop=0010, hi/lo SHALL update on the rising clk edge per funct:
- 18 MULT: signed 64-bit a*b; hi=upper 32 bits, lo=lower 32 bits.
- 19 MULTU: unsigned 64-bit a*b; hi=upper, lo=lower.
- 1A DIV: signed; lo=quotient truncated toward zero; remainder hi takes the sign of the dividend.
- 1B DIVU: unsigned; lo=quotient, hi=remainder.
- 11 MTHI: hi=a, lo unchanged.
- 13 MTLO: lo=a, hi unchanged.
REQ-020 A DIV/DIVU with b==0 SHALL leave hi and lo unchanged.
REQ-021 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-022 Any write=1 with a non-mult/div funct, or with aluop≠0010, SHALL leave hi/lo unchanged.
REQ-023 With write=0, hi/lo SHALL hold their values.
REQ-024 Multiply and divide SHALL complete in a single cycle.
- New hi/lo values are visible immediately after the write edge.
- A same-cycle MFHI/MFLO returns the old value.

Reset
REQ-025 Asserting reset SHALL force hi=0 and lo=0 immediately, without waiting for a clock edge.
REQ-026 While reset is high, write SHALL have no effect on hi/lo.
REQ-027 The first write honoured after reset SHALL be at the first rising edge after reset deasserts.
REQ-028 Reset SHALL NOT affect the combinational result/zero path.
- result/zero still depend on hi/lo, which read 0 during reset.

Verification
REQ-029 ADD/SUB: aluop=0000, a=7FFFFFFF, b=1 -> result=80000000, zero=0. aluop=0001, a=b=5 -> result=0, zero=1.
REQ-030 Shifts and compares:
- SRA: funct=03, b=80000000, shamt=4 -> F8000000.
- SRLV: funct=06, a=4, b=80000000 -> 08000000.
- SLT: a=FFFFFFFF, b=1 -> 1.
- SLTU: same operands -> 0.
REQ-031 MULT with write=1: a=FFFFFFFE (-2), b=3 -> next edge hi=FFFFFFFF, lo=FFFFFFFA. MULTU with same operands -> hi=2, lo=FFFFFFFA.
REQ-032 Divide:
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=0 -> hi/lo unchanged.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-033 Move to/from hi/lo: MTHI a=DEADBEEF, write=1 -> hi=DEADBEEF, lo unchanged. Then MFHI with write=0 -> result=DEADBEEF.
REQ-034 Reset mid-operation: with hi/lo nonzero, assert reset between edges -> hi=lo=0 immediately. A write held high during reset has no effect; it is honoured at the first edge after deassert.
